// File: rtl/riscv_pipe_pkg.sv
// riscv_pipe_pkg: shared encodings for the execute-stage front end.
package riscv_pipe_pkg;
    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;
    localparam logic RESULTSRC_ALU = 1'b0;
    localparam logic RESULTSRC_MEM = 1'b1;
    // MEM wins over WB; x0 is hardwired zero so never a forwarding target.
    function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input logic [4:0] rd_m,
                                           input logic we_m, input logic [4:0] rd_w,
                                           input logic we_w);
        return (we_m && rd_m != 5'd0 && rd_m == rs) ? FWD_MEM :
               (we_w && rd_w != 5'd0 && rd_w == rs) ? FWD_WB : FWD_REG;
    endfunction
endpackage

// File: rtl/id_ex_operand_stage_forwarding_unit.sv
// forwarding_unit: picks the rs1/rs2 operand source from MEM, WB or the register file.
module forwarding_unit
    import riscv_pipe_pkg::*;
(
    input  logic [4:0] RS1_E,
    input  logic [4:0] RS2_E,
    input  logic [4:0] RD_M,
    input  logic [4:0] RD_W,
    input  logic       RegWrite_M,
    input  logic       RegWrite_W,
    output logic [1:0] FwdA,
    output logic [1:0] FwdB
);
    assign FwdA = fwd_sel(RS1_E, RD_M, RegWrite_M, RD_W, RegWrite_W);
    assign FwdB = fwd_sel(RS2_E, RD_M, RegWrite_M, RD_W, RegWrite_W);
endmodule

// File: rtl/id_ex_operand_stage.sv
// id_ex_operand_stage: ID/EX register with stall/flush, operand forwarding,
// immediate select, branch target and load-use detection.
module id_ex_operand_stage
    import riscv_pipe_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            Stall_E,
    input  logic            Flush_E,
    input  logic [XLEN-1:0] RD1_D,
    input  logic [XLEN-1:0] RD2_D,
    input  logic [XLEN-1:0] Imm_Ext_D,
    input  logic [XLEN-1:0] PC_D,
    input  logic [XLEN-1:0] PCPlus4_D,
    input  logic [4:0]      RS1_D,
    input  logic [4:0]      RS2_D,
    input  logic [4:0]      RD_D,
    input  logic            RegWrite_D,
    input  logic            ALUSrc_D,
    input  logic            MemWrite_D,
    input  logic            ResultSrc_D,
    input  logic            Branch_D,
    input  logic [2:0]      ALUControl_D,
    input  logic [XLEN-1:0] ALUResult_M,
    input  logic [4:0]      RD_M,
    input  logic            RegWrite_M,
    input  logic [XLEN-1:0] Result_W,
    input  logic [4:0]      RD_W,
    input  logic            RegWrite_W,
    output logic [XLEN-1:0] SrcA_E,
    output logic [XLEN-1:0] SrcB_E,
    output logic [2:0]      ALUControl_E,
    output logic [XLEN-1:0] WriteData_E,
    output logic [XLEN-1:0] PCTarget_E,
    output logic [XLEN-1:0] PCPlus4_E,
    output logic [4:0]      RD_E,
    output logic            RegWrite_E,
    output logic            MemWrite_E,
    output logic            ResultSrc_E,
    output logic            Branch_E,
    output logic            Valid_E,
    output logic            LoadUse_Hazard
);
    typedef struct packed {
        logic [XLEN-1:0] rd1;
        logic [XLEN-1:0] rd2;
        logic [XLEN-1:0] imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] pc4;
        logic [4:0]      rs1;
        logic [4:0]      rs2;
        logic [4:0]      rd;
        logic            regwrite;
        logic            alusrc;
        logic            memwrite;
        logic            resultsrc;
        logic            branch;
        logic [2:0]      aluc;
        logic            valid;
    } id_ex_t;

    id_ex_t d, q;
    logic [1:0] fwd_a, fwd_b;

    assign d = '{rd1: RD1_D, rd2: RD2_D, imm: Imm_Ext_D, pc: PC_D, pc4: PCPlus4_D,
                 rs1: RS1_D, rs2: RS2_D, rd: RD_D, regwrite: RegWrite_D, alusrc: ALUSrc_D,
                 memwrite: MemWrite_D, resultsrc: ResultSrc_D, branch: Branch_D,
                 aluc: ALUControl_D, valid: 1'b1};

    // An all-zero register is a bubble: no writes, no branch, Valid_E low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            q <= '0;
        else if (Flush_E)
            q <= '0;
        else if (!Stall_E)
            q <= d;
    end

    forwarding_unit u_fwd (
        .RS1_E      (q.rs1),
        .RS2_E      (q.rs2),
        .RD_M       (RD_M),
        .RD_W       (RD_W),
        .RegWrite_M (RegWrite_M),
        .RegWrite_W (RegWrite_W),
        .FwdA       (fwd_a),
        .FwdB       (fwd_b)
    );

    assign SrcA_E      = (fwd_a == FWD_MEM) ? ALUResult_M : (fwd_a == FWD_WB) ? Result_W : q.rd1;
    assign WriteData_E = (fwd_b == FWD_MEM) ? ALUResult_M : (fwd_b == FWD_WB) ? Result_W : q.rd2;
    assign SrcB_E      = q.alusrc ? q.imm : WriteData_E;
    assign PCTarget_E  = q.pc + q.imm;

    assign ALUControl_E = q.aluc;
    assign PCPlus4_E    = q.pc4;
    assign RD_E         = q.rd;
    assign RegWrite_E   = q.regwrite;
    assign MemWrite_E   = q.memwrite;
    assign ResultSrc_E  = q.resultsrc;
    assign Branch_E     = q.branch;
    assign Valid_E      = q.valid;

    assign LoadUse_Hazard = (q.resultsrc == RESULTSRC_MEM) && q.regwrite && (q.rd != 5'd0) &&
                            ((q.rd == RS1_D) || (q.rd == RS2_D));
endmodule

// File: tb/tb_id_ex_operand_stage.sv
// tb_id_ex_operand_stage: directed vectors with a queue-based scoreboard checked at negedge.
module tb_id_ex_operand_stage;
    localparam int F_SRCA = 0, F_SRCB = 1, F_WD = 2, F_PCT = 3, F_VALID = 4;
    localparam int F_LU = 5, F_ALUC = 6, F_CTRL = 7, F_RD = 8, F_PC4 = 9;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        Stall_E = 1'b0, Flush_E = 1'b0;
    logic [31:0] RD1_D = '0, RD2_D = '0, Imm_Ext_D = '0, PC_D = '0, PCPlus4_D = '0;
    logic [4:0]  RS1_D = '0, RS2_D = '0, RD_D = '0;
    logic        RegWrite_D = 1'b0, ALUSrc_D = 1'b0, MemWrite_D = 1'b0;
    logic        ResultSrc_D = 1'b0, Branch_D = 1'b0;
    logic [2:0]  ALUControl_D = '0;
    logic [31:0] ALUResult_M = '0, Result_W = '0;
    logic [4:0]  RD_M = '0, RD_W = '0;
    logic        RegWrite_M = 1'b0, RegWrite_W = 1'b0;
    logic [31:0] SrcA_E, SrcB_E, WriteData_E, PCTarget_E, PCPlus4_E;
    logic [2:0]  ALUControl_E;
    logic [4:0]  RD_E;
    logic        RegWrite_E, MemWrite_E, ResultSrc_E, Branch_E, Valid_E, LoadUse_Hazard;

    id_ex_operand_stage #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .Stall_E(Stall_E), .Flush_E(Flush_E),
        .RD1_D(RD1_D), .RD2_D(RD2_D), .Imm_Ext_D(Imm_Ext_D), .PC_D(PC_D), .PCPlus4_D(PCPlus4_D),
        .RS1_D(RS1_D), .RS2_D(RS2_D), .RD_D(RD_D),
        .RegWrite_D(RegWrite_D), .ALUSrc_D(ALUSrc_D), .MemWrite_D(MemWrite_D),
        .ResultSrc_D(ResultSrc_D), .Branch_D(Branch_D), .ALUControl_D(ALUControl_D),
        .ALUResult_M(ALUResult_M), .RD_M(RD_M), .RegWrite_M(RegWrite_M),
        .Result_W(Result_W), .RD_W(RD_W), .RegWrite_W(RegWrite_W),
        .SrcA_E(SrcA_E), .SrcB_E(SrcB_E), .ALUControl_E(ALUControl_E),
        .WriteData_E(WriteData_E), .PCTarget_E(PCTarget_E), .PCPlus4_E(PCPlus4_E), .RD_E(RD_E),
        .RegWrite_E(RegWrite_E), .MemWrite_E(MemWrite_E), .ResultSrc_E(ResultSrc_E),
        .Branch_E(Branch_E), .Valid_E(Valid_E), .LoadUse_Hazard(LoadUse_Hazard)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       name;
        int          f;
        logic [31:0] v;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad = 0;

    function automatic logic [31:0] get(input int f);
        case (f)
            F_SRCA:  return SrcA_E;
            F_SRCB:  return SrcB_E;
            F_WD:    return WriteData_E;
            F_PCT:   return PCTarget_E;
            F_VALID: return {31'd0, Valid_E};
            F_LU:    return {31'd0, LoadUse_Hazard};
            F_ALUC:  return {29'd0, ALUControl_E};
            F_CTRL:  return {28'd0, RegWrite_E, MemWrite_E, ResultSrc_E, Branch_E};
            F_RD:    return {27'd0, RD_E};
            default: return PCPlus4_E;
        endcase
    endfunction

    // Monitor: drain every expectation queued for this cycle.
    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [31:0] a;
            e = q.pop_front();
            a = get(e.f);
            total++;
            if (a !== e.v) begin
                bad++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", e.name, a, e.v);
            end
        end
    end

    task automatic expect_v(input string n, input int f, input logic [31:0] v);
        q.push_back('{name: n, f: f, v: v});
    endtask

    task automatic expect_bubble(input string n);
        expect_v({n, ".srca"}, F_SRCA, 0);
        expect_v({n, ".srcb"}, F_SRCB, 0);
        expect_v({n, ".wd"}, F_WD, 0);
        expect_v({n, ".pct"}, F_PCT, 0);
        expect_v({n, ".valid"}, F_VALID, 0);
        expect_v({n, ".lu"}, F_LU, 0);
        expect_v({n, ".aluc"}, F_ALUC, 0);
        expect_v({n, ".ctrl"}, F_CTRL, 0);
        expect_v({n, ".rd"}, F_RD, 0);
        expect_v({n, ".pc4"}, F_PC4, 0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctrl = {RegWrite, MemWrite, ResultSrc, Branch}
    task automatic set_d(input logic [31:0] rd1, input logic [31:0] rd2, input logic [31:0] imm,
                         input logic [31:0] pc, input logic [31:0] pc4, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd, input logic [3:0] ctrl,
                         input logic alusrc, input logic [2:0] aluc);
        RD1_D = rd1; RD2_D = rd2; Imm_Ext_D = imm; PC_D = pc; PCPlus4_D = pc4;
        RS1_D = rs1; RS2_D = rs2; RD_D = rd;
        {RegWrite_D, MemWrite_D, ResultSrc_D, Branch_D} = ctrl;
        ALUSrc_D = alusrc; ALUControl_D = aluc;
    endtask

    task automatic set_fwd(input logic wm, input logic [4:0] rdm, input logic [31:0] am,
                           input logic ww, input logic [4:0] rdw, input logic [31:0] rw);
        RegWrite_M = wm; RD_M = rdm; ALUResult_M = am;
        RegWrite_W = ww; RD_W = rdw; Result_W = rw;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // Reset held: garbage on every input must not leak through.
        tick();
        set_d(32'h1, 32'h2, 32'h3, 32'h4, 32'h5, 5'd3, 5'd4, 5'd6, 4'b1111, 1'b1, 3'b011);
        set_fwd(1'b1, 5'd3, 32'hFF, 1'b1, 5'd4, 32'hEE);
        expect_bubble("rst0");
        tick();
        expect_bubble("rst1");
        rst = 1'b1;
        set_d(32'd5, 32'd7, 32'h20, 32'h100, 32'h104, 5'd1, 5'd2, 5'd4, 4'b1000, 1'b0, 3'b001);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        expect_v("post_release.valid", F_VALID, 0);
        // First capture.
        tick();
        expect_v("cap.srca", F_SRCA, 32'd5);
        expect_v("cap.srcb", F_SRCB, 32'd7);
        expect_v("cap.wd", F_WD, 32'd7);
        expect_v("cap.valid", F_VALID, 1);
        expect_v("cap.aluc", F_ALUC, 3'b001);
        expect_v("cap.pct", F_PCT, 32'h120);
        expect_v("cap.pc4", F_PC4, 32'h104);
        expect_v("cap.rd", F_RD, 4);
        expect_v("cap.ctrl", F_CTRL, 4'b1000);
        expect_v("cap.lu", F_LU, 0);
        set_d(32'h11, 32'h22, 32'h10, 32'h200, 32'h204, 5'd3, 5'd6, 5'd7, 4'b1000, 1'b0, 3'b010);
        // Forwarding priority: MEM beats WB.
        tick();
        Stall_E = 1'b1;
        set_fwd(1'b1, 5'd3, 32'hAA, 1'b1, 5'd3, 32'hBB);
        expect_v("fwd_mem.srca", F_SRCA, 32'hAA);
        expect_v("fwd_mem.wd", F_WD, 32'h22);
        expect_v("fwd_mem.srcb", F_SRCB, 32'h22);
        expect_v("fwd_mem.aluc", F_ALUC, 3'b010);
        tick();
        RegWrite_M = 1'b0;
        expect_v("fwd_wb.srca", F_SRCA, 32'hBB);
        tick();
        set_fwd(1'b1, 5'd6, 32'hCC, 1'b1, 5'd3, 32'hBB);
        expect_v("fwd_b_mem.wd", F_WD, 32'hCC);
        expect_v("fwd_b_mem.srcb", F_SRCB, 32'hCC);
        expect_v("fwd_b_mem.srca", F_SRCA, 32'hBB);
        Stall_E = 1'b0;
        set_d(32'h44, 32'h33, 32'h8, 32'hFFFF_FFFC, 32'h0, 5'd0, 5'd0, 5'd5, 4'b1010, 1'b1, 3'b011);
        // x0 guard, immediate select, PC wrap, load-use.
        tick();
        set_fwd(1'b1, 5'd0, 32'hFF, 1'b1, 5'd0, 32'hEE);
        RS1_D = 5'd9;
        RS2_D = 5'd5;
        Flush_E = 1'b1;
        expect_v("x0.wd", F_WD, 32'h33);
        expect_v("x0.srca", F_SRCA, 32'h44);
        expect_v("imm.srcb", F_SRCB, 32'h8);
        expect_v("wrap.pct", F_PCT, 32'h4);
        expect_v("load.ctrl", F_CTRL, 4'b1010);
        expect_v("loaduse.lu", F_LU, 1);
        tick();
        Flush_E = 1'b0;
        expect_bubble("flush");
        set_d(32'h1234, 32'h5678, 32'hC, 32'h40, 32'h44, 5'd10, 5'd11, 5'd12, 4'b0101, 1'b0, 3'b001);
        set_fwd(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0);
        // Stall for three edges while D keeps changing.
        for (int i = 0; i < 4; i++) begin
            tick();
            Stall_E = 1'b1;
            Flush_E = (i == 3);
            set_d(32'hDEAD + i, 32'hBEEF + i, 32'h99, 32'h999, 32'h99C, 5'd20, 5'd21, 5'd22,
                  4'b1000, 1'b1, 3'b000);
            expect_v("stall.srca", F_SRCA, 32'h1234);
            expect_v("stall.srcb", F_SRCB, 32'h5678);
            expect_v("stall.pct", F_PCT, 32'h4C);
            expect_v("stall.ctrl", F_CTRL, 4'b0101);
            expect_v("stall.rd", F_RD, 12);
            expect_v("stall.aluc", F_ALUC, 3'b001);
            expect_v("stall.valid", F_VALID, 1);
        end
        // Stall and flush together: flush wins.
        tick();
        expect_bubble("stall_flush");
        Stall_E = 1'b0;
        Flush_E = 1'b0;
        set_d(32'h77, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'b1000, 1'b0, 3'b000);
        tick();
        expect_v("recap.valid", F_VALID, 1);
        expect_v("recap.srca", F_SRCA, 32'h77);
        Stall_E = 1'b1;
        // Asynchronous reset mid-stall, between edges.
        tick();
        #1 rst = 1'b0;
        expect_v("async_rst.valid", F_VALID, 0);
        expect_v("async_rst.srca", F_SRCA, 0);
        expect_v("async_rst.ctrl", F_CTRL, 0);
        tick();
        rst = 1'b1;
        Stall_E = 1'b0;
        set_d(32'h99, 32'h0, 32'h0, 32'h0, 32'h0, 5'd1, 5'd2, 5'd3, 4'b1000, 1'b0, 3'b000);
        expect_v("rst_release.valid", F_VALID, 0);
        tick();
        expect_v("after_rst.valid", F_VALID, 1);
        expect_v("after_rst.srca", F_SRCA, 32'h99);
        repeat (2) @(posedge clk);
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
